// File: rtl/piso_tx_pkg.sv
// Shared types and constants for the rising-edge parallel-in serial-out transmitter.
package piso_tx_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   localparam logic SD_RST     = 1'b0;
   localparam logic SFRAME_RST = 1'b0;

   // Counter must hold the value WIDTH itself, hence WIDTH+1.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/piso_tx_posedge_if.sv
// Load handshake and serial output bundle of the transmitter.
interface piso_tx_posedge_if #(
   parameter int WIDTH = 8
);
   logic             load_valid;
   logic [WIDTH-1:0] load_data;
   logic             load_ready;
   logic             sd;
   logic             sframe;
   logic             done;

   modport master (
      output load_valid,
      output load_data,
      input  load_ready,
      input  sd,
      input  sframe,
      input  done
   );

   modport slave (
      input  load_valid,
      input  load_data,
      output load_ready,
      output sd,
      output sframe,
      output done
   );
endinterface

// File: rtl/tx_bit_counter.sv
// Position of the bit currently on sd within its word (1..WIDTH, 0 when idle).
module tx_bit_counter
   import piso_tx_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic c,
   input  logic r,
   input  logic load_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic last_o
);
   localparam int CW = cnt_w(WIDTH);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = CW'(1);
      end else if (inc_i && (cnt_q != CW'(WIDTH))) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge c or posedge r) begin
      if (r) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last_o = (cnt_q == CW'(WIDTH));

endmodule

// File: rtl/piso_tx_posedge.sv
// Serial transmitter launching one bit per rising edge for a falling-edge receiver.
//
//   state | meaning
//   IDLE  | no word in flight, load_ready high, sd/sframe low
//   SHIFT | a word is on sd; load_ready only in its last-bit cycle
module piso_tx_posedge
   import piso_tx_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic               c,
   input  logic               r,
   piso_tx_posedge_if.slave   tx
);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             sd_q, sd_d;
   logic             sframe_q, sframe_d;
   logic             done_q, done_d;
   logic             cnt_load, cnt_inc, cnt_clr;
   logic             last_bit;
   logic             ready;

   function automatic logic out_bit(input logic [WIDTH-1:0] w);
      return LSB_FIRST ? w[0] : w[WIDTH-1];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return LSB_FIRST ? (w >> 1) : (w << 1);
   endfunction

   tx_bit_counter #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .c      (c),
      .r      (r),
      .load_i (cnt_load),
      .inc_i  (cnt_inc),
      .clr_i  (cnt_clr),
      .last_o (last_bit)
   );

   // Held low during reset so nothing can be offered while the block is cleared.
   assign ready = !r && ((state_q == IDLE) || last_bit);

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      sd_d     = 1'b0;
      sframe_d = 1'b0;
      done_d   = 1'b0;
      cnt_load = 1'b0;
      cnt_inc  = 1'b0;
      cnt_clr  = 1'b0;
      if ((state_q == SHIFT) && last_bit) begin
         done_d = 1'b1;
      end
      // The first bit goes out on the accept edge; shreg keeps only what follows.
      if (tx.load_valid && ready) begin
         state_d  = SHIFT;
         shreg_d  = advance(tx.load_data);
         sd_d     = out_bit(tx.load_data);
         sframe_d = 1'b1;
         cnt_load = 1'b1;
      end else if (state_q == SHIFT) begin
         if (last_bit) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_clr = 1'b1;
         end else begin
            shreg_d  = advance(shreg_q);
            sd_d     = out_bit(shreg_q);
            sframe_d = 1'b1;
            cnt_inc  = 1'b1;
         end
      end
   end

   always_ff @(posedge c or posedge r) begin
      if (r) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         sd_q     <= SD_RST;
         sframe_q <= SFRAME_RST;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         sd_q     <= sd_d;
         sframe_q <= sframe_d;
         done_q   <= done_d;
      end
   end

   assign tx.load_ready = ready;
   assign tx.sd         = sd_q;
   assign tx.sframe     = sframe_q;
   assign tx.done       = done_q;

endmodule

// File: tb/tb_piso_tx_posedge.sv
// Checks an LSB-first and an MSB-first transmitter against a word/position model.
module tb_piso_tx_posedge;
   localparam int W = 8;

   logic         c = 1'b0;
   logic         r = 1'b1;
   logic         vld [2];
   logic [W-1:0] dat [2];
   logic         sd_a [2];
   logic         sf_a [2];
   logic         dn_a [2];
   logic         rdy_a [2];

   int tests = 0;
   int fails = 0;

   piso_tx_posedge_if #(.WIDTH(W)) if0 ();
   piso_tx_posedge_if #(.WIDTH(W)) if1 ();

   assign if0.load_valid = vld[0];
   assign if0.load_data  = dat[0];
   assign if1.load_valid = vld[1];
   assign if1.load_data  = dat[1];
   assign sd_a[0]  = if0.sd;
   assign sf_a[0]  = if0.sframe;
   assign dn_a[0]  = if0.done;
   assign rdy_a[0] = if0.load_ready;
   assign sd_a[1]  = if1.sd;
   assign sf_a[1]  = if1.sframe;
   assign dn_a[1]  = if1.done;
   assign rdy_a[1] = if1.load_ready;

   piso_tx_posedge #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (.c(c), .r(r), .tx(if0.slave));
   piso_tx_posedge #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (.c(c), .r(r), .tx(if1.slave));

   always #5 c = ~c;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: the word in flight and how many of its bits have been shown.
   bit           busy_m [2];
   int           pos_m  [2];
   logic [W-1:0] word_m [2];
   bit           sd_m   [2];
   bit           dn_m   [2];

   function automatic bit bitof(input int k, input logic [W-1:0] w, input int i);
      return (k == 0) ? w[i] : w[W-1-i];
   endfunction

   function automatic bit ready_m(input int k);
      return !r && (!busy_m[k] || pos_m[k] == W);
   endfunction

   always @(posedge c or posedge r) begin
      for (int k = 0; k < 2; k++) begin
         if (r) begin
            busy_m[k] = 0; pos_m[k] = 0; word_m[k] = '0; sd_m[k] = 0; dn_m[k] = 0;
         end else begin
            bit acc;
            acc = (vld[k] === 1'b1) && ready_m(k);
            dn_m[k] = busy_m[k] && pos_m[k] == W;
            if (acc) begin
               word_m[k] = dat[k]; pos_m[k] = 1; busy_m[k] = 1;
               sd_m[k] = bitof(k, word_m[k], 0);
            end else if (busy_m[k] && pos_m[k] < W) begin
               sd_m[k] = bitof(k, word_m[k], pos_m[k]);
               pos_m[k]++;
            end else begin
               busy_m[k] = 0; pos_m[k] = 0; sd_m[k] = 0;
            end
         end
      end
   end

   always @(negedge c) begin
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("sd[%0d]", k), 32'(sd_a[k]), 32'(sd_m[k]));
         chk($sformatf("sframe[%0d]", k), 32'(sf_a[k]), 32'(busy_m[k]));
         chk($sformatf("done[%0d]", k), 32'(dn_a[k]), 32'(dn_m[k]));
         chk($sformatf("load_ready[%0d]", k), 32'(rdy_a[k]), 32'(ready_m(k)));
      end
   end

   // Falling-edge receivers, done counters and sframe run length.
   bit rx0 [$];
   bit rx1 [$];
   int done_cnt [2] = '{0, 0};
   int run = 0;
   int last_run = 0;

   always @(negedge c) begin
      if (sf_a[0]) rx0.push_back(sd_a[0]);
      if (sf_a[1]) rx1.push_back(sd_a[1]);
      for (int k = 0; k < 2; k++) if (dn_a[k]) done_cnt[k]++;
      if (sf_a[0]) run++;
      else begin
         if (run != 0) last_run = run;
         run = 0;
      end
   end

   // Word ending 'back' words before the most recent capture.
   function automatic logic [W-1:0] rx_word(input int k, input int back);
      logic [W-1:0] w;
      int base;
      w = '0;
      base = ((k == 0) ? rx0.size() : rx1.size()) - W * (back + 1);
      if (base < 0) return 'x;
      for (int i = 0; i < W; i++) begin
         if (k == 0) w[i] = rx0[base + i];
         else        w[W-1-i] = rx1[base + i];
      end
      return w;
   endfunction

   task automatic tick();
      @(posedge c);
      #1;
   endtask

   task automatic send(input int k, input logic [W-1:0] w);
      vld[k] = 1'b1;
      dat[k] = w;
      tick();
      vld[k] = 1'b0;
   endtask

   int d0;

   initial begin
      vld[0] = 0; vld[1] = 0; dat[0] = '0; dat[1] = '0;
      tick();
      for (int k = 0; k < 2; k++) begin
         chk("rst_ready", 32'(rdy_a[k]), 32'd0);
         chk("rst_sd", 32'(sd_a[k]), 32'd0);
         chk("rst_sframe", 32'(sf_a[k]), 32'd0);
      end
      tick();
      r = 1'b0;
      #1;
      chk("release_ready0", 32'(rdy_a[0]), 32'd1);
      chk("release_ready1", 32'(rdy_a[1]), 32'd1);
      tick();
      chk("no_done_after_reset", 32'(done_cnt[0] + done_cnt[1]), 32'd0);

      send(0, 8'hA5);
      repeat (10) tick();
      chk("rx_A5", 32'(rx_word(0, 0)), 32'hA5);
      chk("done_A5", 32'(done_cnt[0]), 32'd1);
      chk("run_A5", 32'(last_run), 32'd8);

      send(1, 8'h81);
      repeat (10) tick();
      chk("rx_81_msb", 32'(rx_word(1, 0)), 32'h81);
      send(1, 8'hC0);
      repeat (10) tick();
      chk("rx_C0_msb", 32'(rx_word(1, 0)), 32'hC0);
      chk("done_msb", 32'(done_cnt[1]), 32'd2);

      d0 = done_cnt[0];
      vld[0] = 1'b1; dat[0] = 8'h0F;
      tick();
      repeat (7) tick();
      dat[0] = 8'hF0;
      tick();
      vld[0] = 1'b0;
      repeat (18) tick();
      chk("b2b_first", 32'(rx_word(0, 1)), 32'h0F);
      chk("b2b_second", 32'(rx_word(0, 0)), 32'hF0);
      chk("b2b_run", 32'(last_run), 32'd16);
      chk("b2b_done", 32'(done_cnt[0] - d0), 32'd2);

      d0 = done_cnt[0];
      send(0, 8'h00);
      tick(); tick();
      vld[0] = 1'b1; dat[0] = 8'hFF;
      tick();
      vld[0] = 1'b0;
      repeat (10) tick();
      chk("ignored_load", 32'(rx_word(0, 0)), 32'h00);
      chk("ignored_done", 32'(done_cnt[0] - d0), 32'd1);

      repeat (400) begin
         for (int k = 0; k < 2; k++) begin
            vld[k] = ($urandom_range(0, 3) != 0);
            dat[k] = W'($urandom);
         end
         tick();
      end
      vld[0] = 0; vld[1] = 0;
      repeat (12) tick();

      vld[0] = 1; vld[1] = 1; dat[0] = 8'h55; dat[1] = 8'h55;
      tick();
      vld[0] = 0; vld[1] = 0;
      repeat (3) tick();
      d0 = done_cnt[0] + done_cnt[1];
      #2;
      r = 1'b1;
      #1;
      chk("async_sd0", 32'(sd_a[0]), 32'd0);
      chk("async_sf0", 32'(sf_a[0]), 32'd0);
      chk("async_sd1", 32'(sd_a[1]), 32'd0);
      chk("async_sf1", 32'(sf_a[1]), 32'd0);
      tick(); tick();
      r = 1'b0;
      tick();
      chk("abandon_no_done", 32'(done_cnt[0] + done_cnt[1]), 32'(d0));
      send(0, 8'h3C);
      repeat (10) tick();
      chk("rx_3C", 32'(rx_word(0, 0)), 32'h3C);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
